// File: rtl/pr_hrav_bitstream_sender.sv
// pr_hrav_bitstream_sender
//   Initiator side of the HR-AV partial-reconfiguration AXI-Stream link.
//   Packs 32-bit bitstream words into 256-bit beats, sends them as AXIS
//   packets tagged {magic, dst, src, seq}, then waits for and validates the
//   configuration-done message from the ICAP controller.
//
//   Optional build macro: PR_HRAV_BS_SWAP_EN
//     When defined, each incoming word is byte-swapped before it is written
//     into the beat register (ICAP bit ordering for raw .bin files).
//
// Ports
//   ACLK, ARESETN           clock, async active-low reset
//   start                   one-cycle transfer request (ignored while busy)
//   bs_*                    32-bit bitstream word stream in
//   M_AXIS_*                256-bit packet stream out to the ICAP controller
//   S_AXIS_*                response stream in from the ICAP controller
//   busy, done, error       status; done/error sticky until next start
//   err_code                00 none, 01 bad magic, 10 bad ports, 11 timeout
//   pkt_cnt, byte_cnt       packets / valid bytes sent in current transfer
module pr_hrav_bitstream_sender #(
    parameter logic [23:0] USER_MAGIC_CODE = 24'hAEECAB,
    parameter logic [7:0]  SRC_PORT        = 8'h01,
    parameter logic [7:0]  DST_PORT        = 8'h04,
    parameter int          MAX_PKT_BEATS   = 16,
    parameter int          TIMEOUT_CYCLES  = 65535
) (
    input  logic         ACLK,
    input  logic         ARESETN,
    input  logic         start,
    input  logic [31:0]  bs_tdata,
    input  logic         bs_tvalid,
    output logic         bs_tready,
    input  logic         bs_tlast,
    output logic [255:0] M_AXIS_TDATA,
    output logic [31:0]  M_AXIS_TSTRB,
    output logic [127:0] M_AXIS_TUSER,
    output logic         M_AXIS_TVALID,
    input  logic         M_AXIS_TREADY,
    output logic         M_AXIS_TLAST,
    input  logic [255:0] S_AXIS_TDATA,
    input  logic [31:0]  S_AXIS_TSTRB,
    input  logic [127:0] S_AXIS_TUSER,
    input  logic         S_AXIS_TVALID,
    output logic         S_AXIS_TREADY,
    input  logic         S_AXIS_TLAST,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [1:0]   err_code,
    output logic [15:0]  pkt_cnt,
    output logic [31:0]  byte_cnt
);

    typedef enum logic [1:0] {IDLE, FILL, SEND, WAIT_RSP} state_t;

    localparam logic [7:0]  LAST_BEAT = 8'(MAX_PKT_BEATS - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [7:0][31:0] beat_q;
    logic [3:0]       w_q;        // words held in the beat register
    logic [7:0]       bip_q;      // beat index within the current packet
    logic             final_q;    // beat register holds the final word
    logic             armed_q;    // low on the first edge after reset release
    logic [15:0]      seq_q, timer_q, pkt_cnt_q;
    logic [31:0]      byte_cnt_q;
    logic             done_q, error_q;
    logic [1:0]       err_q;

    logic start_ok, word_acc, beat_acc, rsp_last, tmo, beat_last;
    logic magic_ok, ports_ok;

    // Response payload and header bits outside the checked fields are unused.
    logic unused_rsp;
    assign unused_rsp = ^{S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER[127:56], S_AXIS_TUSER[15:0]};

    // A start on the edge where reset is released is dropped via armed_q.
    assign start_ok  = start && armed_q && (state_q == IDLE);
    assign word_acc  = (state_q == FILL) && bs_tvalid;
    assign beat_acc  = (state_q == SEND) && M_AXIS_TREADY;
    assign rsp_last  = (state_q == WAIT_RSP) && S_AXIS_TVALID && S_AXIS_TLAST;
    assign tmo       = (state_q == WAIT_RSP) && (timer_q == TMO_LAST);
    assign beat_last = (bip_q == LAST_BEAT) || final_q;
    assign magic_ok  = (S_AXIS_TUSER[55:32] == USER_MAGIC_CODE);
    // Responder swaps the ports: its dst is us, its src is the controller.
    assign ports_ok  = (S_AXIS_TUSER[31:24] == SRC_PORT) && (S_AXIS_TUSER[23:16] == DST_PORT);

    function automatic logic [31:0] word_in(input logic [31:0] d);
`ifdef PR_HRAV_BS_SWAP_EN
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
        return d;
`endif
    endfunction

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        bs_tready     = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = 1'b0;
        busy          = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start_ok) state_d = FILL;
            end
            FILL: begin
                bs_tready = 1'b1;
                if (word_acc && (w_q == 4'd7 || bs_tlast)) state_d = SEND;
            end
            SEND: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TLAST  = beat_last;
                if (beat_acc) state_d = final_q ? WAIT_RSP : FILL;
            end
            WAIT_RSP: begin
                S_AXIS_TREADY = 1'b1;
                if (rsp_last || tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            beat_q     <= '0;
            w_q        <= '0;
            bip_q      <= '0;
            final_q    <= 1'b0;
            armed_q    <= 1'b0;
            seq_q      <= '0;
            timer_q    <= '0;
            pkt_cnt_q  <= '0;
            byte_cnt_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_q      <= 2'b00;
        end else begin
            armed_q <= 1'b1;
            if (start_ok) begin
                beat_q     <= '0;
                w_q        <= '0;
                bip_q      <= '0;
                final_q    <= 1'b0;
                seq_q      <= '0;
                timer_q    <= '0;
                pkt_cnt_q  <= '0;
                byte_cnt_q <= '0;
                done_q     <= 1'b0;
                error_q    <= 1'b0;
                err_q      <= 2'b00;
            end
            if (word_acc) begin
                beat_q[w_q[2:0]] <= word_in(bs_tdata);
                w_q              <= w_q + 4'd1;
                if (bs_tlast) final_q <= 1'b1;
            end
            if (beat_acc) begin
                byte_cnt_q <= byte_cnt_q + {26'd0, w_q, 2'b00};
                if (beat_last) begin
                    pkt_cnt_q <= pkt_cnt_q + 16'd1;
                    seq_q     <= seq_q + 16'd1;
                    bip_q     <= '0;
                end else begin
                    bip_q <= bip_q + 8'd1;
                end
                // Cleared so unfilled slots of a short final beat read as zero.
                beat_q  <= '0;
                w_q     <= '0;
                timer_q <= '0;
            end
            if (state_q == WAIT_RSP) begin
                // Response TLAST takes priority over a same-cycle timeout.
                if (rsp_last) begin
                    if (!magic_ok) begin
                        error_q <= 1'b1;
                        err_q   <= 2'b01;
                    end else if (!ports_ok) begin
                        error_q <= 1'b1;
                        err_q   <= 2'b10;
                    end else begin
                        done_q <= 1'b1;
                    end
                end else if (tmo) begin
                    error_q <= 1'b1;
                    err_q   <= 2'b11;
                end else begin
                    timer_q <= timer_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        M_AXIS_TSTRB = '0;
        for (int i = 0; i < 8; i++) M_AXIS_TSTRB[4*i +: 4] = {4{w_q > 4'(i)}};
    end

    assign M_AXIS_TDATA = beat_q;
    assign M_AXIS_TUSER = {72'h0, USER_MAGIC_CODE, DST_PORT, SRC_PORT, seq_q};
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign byte_cnt     = byte_cnt_q;

endmodule
